// File: rtl/bbq_queue_monitor_if.sv
// Signal bundle for the BBQ queue monitor: button/teller inputs and the
// flag and 7-segment outputs. The design uses the slave view, the
// environment that presses buttons uses the master view.
interface bbq_queue_monitor_if;
  logic       Up;
  logic       Down;
  logic [1:0] Tcount;
  logic       Empty_Flag;
  logic       Full_Flag;
  logic       Alarm_Flag;
  logic [6:0] led0_Pcount;
  logic [6:0] led1_Pcount;
  logic [6:0] led0_Wtime;
  logic [6:0] led1_Wtime;

  modport master (
    output Up, Down, Tcount,
    input  Empty_Flag, Full_Flag, Alarm_Flag,
    input  led0_Pcount, led1_Pcount, led0_Wtime, led1_Wtime
  );

  modport slave (
    input  Up, Down, Tcount,
    output Empty_Flag, Full_Flag, Alarm_Flag,
    output led0_Pcount, led1_Pcount, led0_Wtime, led1_Wtime
  );
endinterface

// File: rtl/bbq_queue_monitor.sv
// Queue-occupancy and wait-time monitor for one service line.
// A saturating 3-bit person counter follows Up/Down requests, raises
// empty/full flags and a one-cycle alarm on rejected requests, and the
// estimated wait time is looked up from {Tcount, Pcount}. Both values are
// shown on two 7-segment digits each (active-high, bit0=a .. bit6=g).
//
// Optional feature: define BBQ_EDGE_DETECT_EN to make Up/Down act on rising
// edges only (one step per press). Without it requests are level-sensitive.
module bbq_queue_monitor #(
  parameter int unsigned SVC_TIME = 3  // minutes per customer per teller, 1..4
) (
  input  logic           CLK,
  input  logic           reset,
  bbq_queue_monitor_if.slave bus
);

  logic [2:0] pcount;
  logic       alarm;
  logic       up_req;
  logic       down_req;

`ifdef BBQ_EDGE_DETECT_EN
  logic up_q;
  logic down_q;

  // Remember last cycle's button levels so a held button requests only once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= bus.Up;
      down_q <= bus.Down;
    end
  end

  assign up_req   = bus.Up   & ~up_q;
  assign down_req = bus.Down & ~down_q;
`else
  assign up_req   = bus.Up;
  assign down_req = bus.Down;
`endif

  // Saturating person counter; alarm flags a request that hit a limit.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pcount <= 3'd0;
      alarm  <= 1'b0;
    end else begin
      alarm <= 1'b0;
      if (up_req && !down_req) begin
        if (pcount != 3'd7) pcount <= pcount + 3'd1;
        else                alarm  <= 1'b1;
      end else if (down_req && !up_req) begin
        if (pcount != 3'd0) pcount <= pcount - 3'd1;
        else                alarm  <= 1'b1;
      end
    end
  end

  assign bus.Empty_Flag = (pcount == 3'd0);
  assign bus.Full_Flag  = (pcount == 3'd7);
  assign bus.Alarm_Flag = alarm;

  // Wait time = floor(SVC_TIME*(P+T-1)/T), zero with no customers or tellers.
  // Kept 8 bits wide; legal SVC_TIME keeps the value below 32.
  logic [7:0] num;
  logic [7:0] wtime;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    num   = 8'(SVC_TIME) * (8'(pcount) + 8'(bus.Tcount) - 8'd1);
    wtime = 8'd0;
    if (pcount != 3'd0) begin
      case (bus.Tcount)
        2'd1:    wtime = num;
        2'd2:    wtime = num >> 1;
        2'd3:    wtime = num / 8'd3;
        default: wtime = 8'd0;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [7:0] digit);
    case (digit)
      8'd0:    seg7 = 7'h3F;
      8'd1:    seg7 = 7'h06;
      8'd2:    seg7 = 7'h5B;
      8'd3:    seg7 = 7'h4F;
      8'd4:    seg7 = 7'h66;
      8'd5:    seg7 = 7'h6D;
      8'd6:    seg7 = 7'h7D;
      8'd7:    seg7 = 7'h07;
      8'd8:    seg7 = 7'h7F;
      8'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [7:0] pval;

  // Split both values into tens/units and encode each digit.
  always_comb begin
    pval            = {5'd0, pcount};
    bus.led0_Pcount = seg7(pval % 8'd10);
    bus.led1_Pcount = seg7(pval / 8'd10);
    bus.led0_Wtime  = seg7(wtime % 8'd10);
    bus.led1_Wtime  = seg7(wtime / 8'd10);
  end

endmodule

// File: tb/tb_bbq_queue_monitor.sv
// Self-checking bench for bbq_queue_monitor: directed sequences from the
// test plan followed by random button/teller/reset traffic, all compared
// against an integer reference model of the queue rules.
module tb_bbq_queue_monitor;

  localparam int SVC = 3;

  logic CLK = 1'b0;
  logic reset;

  bbq_queue_monitor_if bus ();

  bbq_queue_monitor #(.SVC_TIME(SVC)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_p       = 0;
  int m_alarm   = 0;
  int m_prev_up = 0;
  int m_prev_dn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'h3F;
      1:       return 7'h06;
      2:       return 7'h5B;
      3:       return 7'h4F;
      4:       return 7'h66;
      5:       return 7'h6D;
      6:       return 7'h7D;
      7:       return 7'h07;
      8:       return 7'h7F;
      9:       return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int wait_of(input int p, input int t);
    if (p == 0 || t == 0) return 0;
    return (SVC * (p + t - 1)) / t;
  endfunction

  task automatic compare_all(input int t);
    int w;
    w = wait_of(m_p, t);
    check("empty",       32'(bus.Empty_Flag),  32'(m_p == 0));
    check("full",        32'(bus.Full_Flag),   32'(m_p == 7));
    check("alarm",       32'(bus.Alarm_Flag),  32'(m_alarm));
    check("led0_pcount", 32'(bus.led0_Pcount), 32'(seg_of(m_p % 10)));
    check("led1_pcount", 32'(bus.led1_Pcount), 32'(seg_of(m_p / 10)));
    check("led0_wtime",  32'(bus.led0_Wtime),  32'(seg_of(w % 10)));
    check("led1_wtime",  32'(bus.led1_Wtime),  32'(seg_of(w / 10)));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic cycle(input logic up, input logic dn, input logic [1:0] t, input logic rst);
    int ru, rd;
    bus.Up     = up;
    bus.Down   = dn;
    bus.Tcount = t;
    reset      = rst;
    @(posedge CLK);
    if (rst) begin
      m_p = 0; m_alarm = 0; m_prev_up = 0; m_prev_dn = 0;
    end else begin
`ifdef BBQ_EDGE_DETECT_EN
      ru = (up && m_prev_up == 0) ? 1 : 0;
      rd = (dn && m_prev_dn == 0) ? 1 : 0;
`else
      ru = up ? 1 : 0;
      rd = dn ? 1 : 0;
`endif
      m_alarm = 0;
      if (ru == 1 && rd == 0) begin
        if (m_p < 7) m_p++; else m_alarm = 1;
      end else if (rd == 1 && ru == 0) begin
        if (m_p > 0) m_p--; else m_alarm = 1;
      end
      m_prev_up = up ? 1 : 0;
      m_prev_dn = dn ? 1 : 0;
    end
    #1;
    compare_all(int'(t));
  endtask

  initial begin
    bus.Up = 1'b0; bus.Down = 1'b0; bus.Tcount = 2'd0; reset = 1'b1;

    // Reset, then idle with no tellers.
    cycle(1'b0, 1'b0, 2'd0, 1'b1);
    check("rst_led0_pcount", 32'(bus.led0_Pcount), 32'h3F);
    check("rst_empty",       32'(bus.Empty_Flag),  32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0);

    // Hold Up for 8 cycles.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 2'd0, 1'b0);
`ifndef BBQ_EDGE_DETECT_EN
    check("up8_pcount", 32'(bus.led0_Pcount), 32'h07);
    check("up8_full",   32'(bus.Full_Flag),   32'd1);
    check("up8_alarm",  32'(bus.Alarm_Flag),  32'd1);
    check("up8_wtime0", 32'(bus.led0_Wtime),  32'h3F);
`else
    check("up8_edge_pcount", 32'(bus.led0_Pcount), 32'h06);
`endif

    // Wait-time lookup at the current count, teller count swept.
    cycle(1'b0, 1'b0, 2'd1, 1'b0);
`ifndef BBQ_EDGE_DETECT_EN
    check("w21_tens",  32'(bus.led1_Wtime), 32'h5B);
    check("w21_units", 32'(bus.led0_Wtime), 32'h06);
`endif
    cycle(1'b0, 1'b0, 2'd2, 1'b0);
`ifndef BBQ_EDGE_DETECT_EN
    check("w12_tens",  32'(bus.led1_Wtime), 32'h06);
    check("w12_units", 32'(bus.led0_Wtime), 32'h5B);
`endif
    cycle(1'b0, 1'b0, 2'd3, 1'b0);
`ifndef BBQ_EDGE_DETECT_EN
    check("w9_tens",   32'(bus.led1_Wtime), 32'h3F);
    check("w9_units",  32'(bus.led0_Wtime), 32'h6F);
`endif
    // Zero-latency lookup: change Tcount between edges.
    for (int t = 0; t < 4; t++) begin
      bus.Tcount = 2'(t);
      #1;
      check("comb_led0_wtime", 32'(bus.led0_Wtime), 32'(seg_of(wait_of(m_p, t) % 10)));
      check("comb_led1_wtime", 32'(bus.led1_Wtime), 32'(seg_of(wait_of(m_p, t) / 10)));
    end

    // Down twice with two tellers, then down to empty and beyond.
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 2'd2, 1'b0);
`ifndef BBQ_EDGE_DETECT_EN
    check("p5t2_units", 32'(bus.led0_Wtime), 32'h6F);
`endif
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'd2, 1'b0);
`ifndef BBQ_EDGE_DETECT_EN
    check("down_empty",   32'(bus.Empty_Flag), 32'd1);
    check("down_noalarm", 32'(bus.Alarm_Flag), 32'd0);
`endif
    cycle(1'b0, 1'b1, 2'd2, 1'b0);
`ifndef BBQ_EDGE_DETECT_EN
    check("down_alarm", 32'(bus.Alarm_Flag), 32'd1);
`endif

    // Up to three, then both buttons together.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 2'd1, 1'b0);
      cycle(1'b0, 1'b0, 2'd1, 1'b0);
    end
    cycle(1'b1, 1'b1, 2'd1, 1'b0);
    check("both_pcount", 32'(bus.led0_Pcount), 32'h4F);
    check("both_alarm",  32'(bus.Alarm_Flag),  32'd0);

    // Reset mid-count overrides a held Up.
    cycle(1'b1, 1'b0, 2'd3, 1'b1);
    check("midrst_pcount", 32'(bus.led0_Pcount), 32'h3F);
    check("midrst_empty",  32'(bus.Empty_Flag),  32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic up, dn, rs;
      logic [1:0] t;
      up = ($urandom_range(0, 99) < 45);
      dn = ($urandom_range(0, 99) < 40);
      rs = ($urandom_range(0, 99) < 2);
      t  = 2'($urandom_range(0, 3));
      cycle(up, dn, t, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
